// File: rtl/instr_fetch.sv
// Instruction fetch: walks pc through instruction memory, hands each word
// to the instruction register with a one-cycle im_r strobe, stops on HALT_OP.
//
// Ports:
//   clock, reset          clock and asynchronous active-high reset
//   start                 leave IDLE and begin fetching at pc
//   stall                 hold the captured word undelivered
//   pc_load, pc_in        redirect pc (highest priority)
//   im_ack, im_data       memory response for im_addr
//   im_req, im_addr       memory read request, im_addr tracks pc
//   im_out, im_r          captured word and its load strobe
//   pc, busy, halted      status
module instr_fetch #(
  parameter int          ADDR_W  = 16,
  parameter int          DATA_W  = 32,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              im_ack,
  input  logic [DATA_W-1:0] im_data,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_out,
  output logic              im_r,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   im_out_q, im_out_d;
  logic                im_req_q, im_req_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic                deliver;
  logic                is_halt;

  assign is_halt = (im_out_q[DATA_W-1 -: 4] == HALT_OP);

  // Strobe only in a DELIVER cycle that is neither stalled nor redirected.
  assign deliver = (state_q == DELIVER) && !stall && !pc_load;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    im_out_d = im_out_q;
    if (pc_load) begin
      pc_d = pc_in;
      unique case (state_q)
        IDLE:    state_d = IDLE;
        HALTED:  state_d = IDLE;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) state_d = FETCH;
        end
        FETCH: begin
          if (im_ack) begin
            im_out_d = im_data;
            state_d  = DELIVER;
          end
        end
        DELIVER: begin
          if (!stall) begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = is_halt ? HALTED : FETCH;
          end
        end
        HALTED: state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs are registered from the next state.
  always_comb begin
    im_req_d = (state_d == FETCH);
    busy_d   = (state_d == FETCH) || (state_d == DELIVER);
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      im_out_q <= '0;
      im_req_q <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      im_out_q <= im_out_d;
      im_req_q <= im_req_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign im_req  = im_req_q;
  assign im_addr = pc_q;
  assign im_out  = im_out_q;
  assign im_r    = deliver;
  assign pc      = pc_q;
  assign busy    = busy_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic,
// all checked against a behavioural model of the fetch rules.
module tb_instr_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, stall, pc_load, im_ack;
  logic [15:0] pc_in;
  logic [31:0] im_data;
  logic        im_req, im_r, busy, halted;
  logic [15:0] im_addr, pc;
  logic [31:0] im_out;

  instr_fetch dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .stall   (stall),
    .pc_load (pc_load),
    .pc_in   (pc_in),
    .im_ack  (im_ack),
    .im_data (im_data),
    .im_req  (im_req),
    .im_addr (im_addr),
    .im_out  (im_out),
    .im_r    (im_r),
    .pc      (pc),
    .busy    (busy),
    .halted  (halted)
  );

  always #5 clock = ~clock;

  int vecs = 0;
  int errs = 0;

  // Model: mode 0 idle, 1 waiting for memory, 2 holding a word, 3 stopped.
  int          m_mode;
  logic [15:0] m_pc;
  logic [31:0] m_out;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 16'h0;
    m_out  = 32'h0;
  endtask

  task automatic model_step();
    if (pc_load) begin
      m_pc   = pc_in;
      m_mode = (m_mode == 0 || m_mode == 3) ? 0 : 1;
    end else if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (im_ack) begin
        m_out  = im_data;
        m_mode = 2;
      end
    end else if (m_mode == 2) begin
      if (!stall) begin
        m_pc   = m_pc + 16'd1;
        m_mode = (m_out[31:28] == 4'hF) ? 3 : 1;
      end
    end
  endtask

  task automatic check_all();
    chk("im_req", {31'b0, im_req}, {31'b0, m_mode == 1});
    chk("busy", {31'b0, busy}, {31'b0, m_mode == 1 || m_mode == 2});
    chk("halted", {31'b0, halted}, {31'b0, m_mode == 3});
    chk("im_r", {31'b0, im_r},
        {31'b0, m_mode == 2 && !stall && !pc_load});
    chk("pc", {16'b0, pc}, {16'b0, m_pc});
    chk("im_addr", {16'b0, im_addr}, {16'b0, m_pc});
    chk("im_out", im_out, m_out);
  endtask

  // One clock: apply inputs, check mid-cycle, clock model with DUT.
  task automatic cyc(input logic st, input logic sl, input logic ld,
                     input logic [15:0] pi, input logic ak,
                     input logic [31:0] dt);
    start   = st;
    stall   = sl;
    pc_load = ld;
    pc_in   = pi;
    im_ack  = ak;
    im_data = dt;
    @(negedge clock);
    check_all();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, {16'b0, pc}, 32'h0);
    chk({tag, "_im_out"}, im_out, 32'h0);
    chk({tag, "_im_req"}, {31'b0, im_req}, 32'h0);
    chk({tag, "_im_r"}, {31'b0, im_r}, 32'h0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
    chk({tag, "_halted"}, {31'b0, halted}, 32'h0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    stall   = 1'b0;
    pc_load = 1'b0;
    pc_in   = 16'h0;
    im_ack  = 1'b0;
    im_data = 32'h0;
    model_reset();
    #2;
    chk_reset_vals("por");
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Stay idle without start
    cyc(0, 0, 0, 16'h0, 1, 32'hDEAD_BEEF);
    cyc(0, 0, 0, 16'h0, 0, 32'h0);
    chk("idle_busy", {31'b0, busy}, 32'h0);

    // Basic fetch of 1234_5678
    cyc(1, 0, 0, 16'h0, 0, 32'h0);
    chk("fetch_req", {31'b0, im_req}, 32'h1);
    cyc(0, 0, 0, 16'h0, 1, 32'h1234_5678);
    chk("cap_word", im_out, 32'h1234_5678);
    cyc(0, 0, 0, 16'h0, 0, 32'h0);
    chk("pc_after1", {16'b0, pc}, 32'h1);
    chk("req_addr1", {15'b0, im_req, im_addr}, 32'h1_0001);

    // Three stalled cycles, then a single strobe
    cyc(0, 0, 0, 16'h0, 1, 32'hAAAA_0001);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 16'h0, 1, 32'h0);
      chk("stall_pc", {16'b0, pc}, 32'h1);
    end
    cyc(0, 0, 0, 16'h0, 0, 32'h0);
    chk("pc_after_stall", {16'b0, pc}, 32'h2);

    // Halt opcode fetched at pc 5
    cyc(0, 0, 1, 16'h0005, 0, 32'h0);
    cyc(0, 0, 0, 16'h0, 1, 32'hF000_0000);
    cyc(0, 0, 0, 16'h0, 0, 32'h0);
    chk("halt_pc", {16'b0, pc}, 32'h6);
    chk("halt_flag", {31'b0, halted}, 32'h1);
    cyc(1, 0, 0, 16'h0, 1, 32'h0);
    chk("halt_sticky", {31'b0, halted}, 32'h1);
    cyc(0, 0, 1, 16'h0020, 0, 32'h0);
    chk("halt_exit_pc", {16'b0, pc}, 32'h20);
    chk("halt_exit_idle", {30'b0, busy, halted}, 32'h0);

    // Redirect in the same cycle as the ack
    cyc(1, 0, 0, 16'h0, 0, 32'h0);
    cyc(0, 0, 1, 16'h0100, 1, 32'h5555_5555);
    chk("redir_keep", im_out, 32'hF000_0000);
    chk("redir_addr", {15'b0, im_req, im_addr}, 32'h1_0100);

    // pc wrap
    cyc(0, 0, 1, 16'hFFFF, 0, 32'h0);
    cyc(0, 0, 0, 16'h0, 1, 32'h0000_0001);
    cyc(0, 0, 0, 16'h0, 0, 32'h0);
    chk("wrap_addr", {15'b0, im_req, im_addr}, 32'h1_0000);

    // Asynchronous reset while fetching
    reset = 1'b1;
    #2;
    chk_reset_vals("async");
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset while holding a word: no strobe survives
    cyc(1, 0, 0, 16'h0, 0, 32'h0);
    cyc(0, 0, 0, 16'h0, 1, 32'h0BAD_0BAD);
    stall = 1'b0;
    reset = 1'b1;
    #1;
    chk_reset_vals("abort");
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] d;
      logic [15:0] t;
      d = $urandom;
      if ($urandom_range(3) == 0) d[31:28] = 4'hF;
      t = 16'($urandom);
      if ($urandom_range(7) == 0) t = 16'hFFFF;
      cyc(1'($urandom_range(1)), ($urandom_range(2) == 0),
          ($urandom_range(9) == 0), t, 1'($urandom_range(1)), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
